// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between three writeback
//   requesters. The debug/loader port always wins. The ALU and the memory
//   unit round-robin between themselves. The winning write is registered for
//   one cycle and then drives the register file's WB/rd/rd_data. Writes to R0
//   are accepted (ready is given) but they never assert wb_en. A saturating
//   counter tracks committed non-R0 writes.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   dbg_valid/rd/data     debug write request (top priority)
//   dbg_ready             debug request accepted this cycle
//   alu_valid/rd/data     ALU writeback request
//   alu_ready             ALU request accepted this cycle
//   mem_valid/rd/data     load writeback request
//   mem_ready             load request accepted this cycle
//   wb_en, wb_rd, wb_data registered write toward the register file
//   stall                 some valid requester was not granted this cycle
//   wr_count              committed non-R0 writes, saturating at all-ones
//
// Optional feature (macro WBARB_FWD_EN)
//   Adds fwd_rs/fwd_rt (in) and fwd_rs_hit/fwd_rt_hit/fwd_data (out). These
//   let decode bypass the write that is pending in the output register.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_rd,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [CNT_W-1:0]  wr_count
`ifdef WBARB_FWD_EN
   ,input  logic [ADDR_W-1:0] fwd_rs,
    input  logic [ADDR_W-1:0] fwd_rt,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // The round-robin pointer remembers which of ALU/MEM won the last shared
    // grant. Reset value MEM means the ALU wins the first tie.
    typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    rr_t     rr_last, rr_next;
    logic    gnt_dbg, gnt_alu, gnt_mem;
    logic    xfer;
    wb_req_t sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_last <= RR_MEM;
        else       rr_last <= rr_next;
    end

    // The grant is also the ready signal. A grant is only ever issued to a
    // valid requester, so every grant is a transfer.
    always_comb begin
        gnt_dbg = 1'b0;
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        rr_next = rr_last;
        if (dbg_valid) begin
            gnt_dbg = 1'b1;
        end else if (alu_valid && mem_valid) begin
            if (rr_last == RR_MEM) gnt_alu = 1'b1;
            else                   gnt_mem = 1'b1;
        end else if (alu_valid) begin
            gnt_alu = 1'b1;
        end else if (mem_valid) begin
            gnt_mem = 1'b1;
        end
        // A debug transfer leaves the ALU/MEM fairness state untouched.
        if (gnt_alu) rr_next = RR_ALU;
        if (gnt_mem) rr_next = RR_MEM;
    end

    always_comb begin
        sel = '0;
        if (gnt_dbg)      sel = '{rd: dbg_rd, data: dbg_data};
        else if (gnt_alu) sel = '{rd: alu_rd, data: alu_data};
        else if (gnt_mem) sel = '{rd: mem_rd, data: mem_data};
    end

    assign xfer      = gnt_dbg | gnt_alu | gnt_mem;
    assign dbg_ready = gnt_dbg;
    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign stall     = (alu_valid && !gnt_alu) || (mem_valid && !gnt_mem)
                    || (dbg_valid && !gnt_dbg);

    // Output stage. wb_rd and wb_data keep their last values when idle. Only
    // wb_en carries meaning for the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wr_count <= '0;
        end else begin
            wb_en <= xfer && (sel.rd != '0);
            if (xfer) begin
                wb_rd   <= sel.rd;
                wb_data <= sel.data;
            end
            if (xfer && (sel.rd != '0) && (wr_count != '1))
                wr_count <= wr_count + CNT_W'(1);
        end
    end

`ifdef WBARB_FWD_EN
    // R0 is never forwarded. It reads as zero architecturally, whatever is
    // pending.
    assign fwd_rs_hit = wb_en && (wb_rd == fwd_rs) && (fwd_rs != '0);
    assign fwd_rt_hit = wb_en && (wb_rd == fwd_rt) && (fwd_rt != '0);
    assign fwd_data   = wb_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. It uses CNT_W=4 so that counter saturation
// can be reached quickly. The checks are a directed table, hand sequences
// for reset and saturation, and a randomized run compared against a
// request-level model.
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic reset;
    logic dbg_valid, alu_valid, mem_valid;
    logic [ADDR_W-1:0] dbg_rd, alu_rd, mem_rd;
    logic [DATA_W-1:0] dbg_data, alu_data, mem_data;
    logic dbg_ready, alu_ready, mem_ready;
    logic wb_en, stall;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  wr_count;
`ifdef WBARB_FWD_EN
    logic [ADDR_W-1:0] fwd_rs, fwd_rt;
    logic fwd_rs_hit, fwd_rt_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .wr_count(wr_count)
`ifdef WBARB_FWD_EN
       ,.fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_rs_hit(fwd_rs_hit),
        .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [ADDR_W-1:0] drd, input logic [DATA_W-1:0] dd,
                         input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                         input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        dbg_valid = dv; dbg_rd = drd; dbg_data = dd;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    // Requester-rule monitor. A request that is still waiting must not change
    // until it sees ready.
    logic       hold_v [3];
    logic [ADDR_W+DATA_W-1:0] hold_p [3];
    initial for (int k = 0; k < 3; k++) hold_v[k] = 1'b0;
    always @(negedge clk) begin
        logic v [3];
        logic r [3];
        logic [ADDR_W+DATA_W-1:0] p [3];
        v[0] = dbg_valid; r[0] = dbg_ready; p[0] = {dbg_rd, dbg_data};
        v[1] = alu_valid; r[1] = alu_ready; p[1] = {alu_rd, alu_data};
        v[2] = mem_valid; r[2] = mem_ready; p[2] = {mem_rd, mem_data};
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                hold_v[k] = 1'b0;
            end else begin
                if (hold_v[k]) begin
                    checks++;
                    if (!v[k] || p[k] != hold_p[k]) begin
                        failures++;
                        $display("FAIL requester_rule src%0d: valid=%0b payload=%0h held=%0h",
                                 k, v[k], p[k], hold_p[k]);
                    end
                end
                hold_v[k] = v[k] && !r[k];
                hold_p[k] = p[k];
            end
        end
    end

    typedef struct {
        logic dv; logic [ADDR_W-1:0] drd; logic [DATA_W-1:0] dd;
        logic av; logic [ADDR_W-1:0] ard; logic [DATA_W-1:0] ad;
        logic mv; logic [ADDR_W-1:0] mrd; logic [DATA_W-1:0] md;
        logic dr, ar, mr, st;
        logic en; logic [ADDR_W-1:0] erd; logic [DATA_W-1:0] edata; logic [CNT_W-1:0] cnt;
    } vec_t;

    function automatic vec_t mk(
        logic dv, logic [ADDR_W-1:0] drd, logic [DATA_W-1:0] dd,
        logic av, logic [ADDR_W-1:0] ard, logic [DATA_W-1:0] ad,
        logic mv, logic [ADDR_W-1:0] mrd, logic [DATA_W-1:0] md,
        logic dr, logic ar, logic mr, logic st,
        logic en, logic [ADDR_W-1:0] erd, logic [DATA_W-1:0] edata, logic [CNT_W-1:0] cnt);
        vec_t v;
        v = '{dv, drd, dd, av, ard, ad, mv, mrd, md, dr, ar, mr, st, en, erd, edata, cnt};
        return v;
    endfunction

    vec_t tbl [$];

    // Randomized-run model state
    logic             p_v [3];
    logic [ADDR_W-1:0] p_rd [3];
    logic [DATA_W-1:0] p_d [3];
    logic             last_mem;
    logic             m_en;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_cnt;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef WBARB_FWD_EN
        fwd_rs = '0; fwd_rt = '0;
`endif
        // Directed vectors. Each row lasts one cycle. The expected wb_* and
        // wr_count values are the ones seen after that cycle's edge.
        tbl.push_back(mk(0,0,0,       1,3,16'hBEEF, 0,0,0,          0,1,0,0, 1,3,16'hBEEF,1));
        tbl.push_back(mk(0,0,0,       0,0,0,        1,4,16'h4444,   0,0,1,0, 1,4,16'h4444,2));
        tbl.push_back(mk(0,0,0,       1,1,16'h1111, 1,2,16'h2222,   0,1,0,1, 1,1,16'h1111,3));
        tbl.push_back(mk(0,0,0,       1,1,16'h1111, 1,2,16'h2222,   0,0,1,1, 1,2,16'h2222,4));
        tbl.push_back(mk(0,0,0,       1,1,16'h1111, 1,2,16'h2222,   0,1,0,1, 1,1,16'h1111,5));
        tbl.push_back(mk(0,0,0,       1,1,16'h1111, 1,2,16'h2222,   0,0,1,1, 1,2,16'h2222,6));
        tbl.push_back(mk(1,5,16'h5555,1,1,16'h1111, 1,2,16'h2222,   1,0,0,1, 1,5,16'h5555,7));
        tbl.push_back(mk(1,5,16'h5555,1,1,16'h1111, 1,2,16'h2222,   1,0,0,1, 1,5,16'h5555,8));
        tbl.push_back(mk(1,5,16'h5555,1,1,16'h1111, 1,2,16'h2222,   1,0,0,1, 1,5,16'h5555,9));
        tbl.push_back(mk(0,0,0,       1,1,16'h1111, 1,2,16'h2222,   0,1,0,1, 1,1,16'h1111,10));
        tbl.push_back(mk(0,0,0,       0,0,0,        1,2,16'h2222,   0,0,1,0, 1,2,16'h2222,11));
        tbl.push_back(mk(0,0,0,       0,0,0,        1,0,16'hFFFF,   0,0,1,0, 0,0,16'hFFFF,11));
        tbl.push_back(mk(0,0,0,       0,0,0,        0,0,0,          0,0,0,0, 0,0,16'hFFFF,11));
        tbl.push_back(mk(1,0,16'h1234,0,0,0,        0,0,0,          1,0,0,0, 0,0,16'h1234,11));
        tbl.push_back(mk(1,7,16'h7777,0,0,0,        0,0,0,          1,0,0,0, 1,7,16'h7777,12));

        repeat (2) @(posedge clk);
        #1;
        chk("reset.wb_en", 32'(wb_en), 0);
        chk("reset.wb_rd", 32'(wb_rd), 0);
        chk("reset.wb_data", 32'(wb_data), 0);
        chk("reset.wr_count", 32'(wr_count), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].dv, tbl[i].drd, tbl[i].dd, tbl[i].av, tbl[i].ard, tbl[i].ad,
                  tbl[i].mv, tbl[i].mrd, tbl[i].md);
            #1;
            chk($sformatf("v%0d.dbg_ready", i), 32'(dbg_ready), 32'(tbl[i].dr));
            chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].ar));
            chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(tbl[i].mr));
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(tbl[i].st));
            @(posedge clk); #1;
            chk($sformatf("v%0d.wb_en", i), 32'(wb_en), 32'(tbl[i].en));
            chk($sformatf("v%0d.wb_rd", i), 32'(wb_rd), 32'(tbl[i].erd));
            chk($sformatf("v%0d.wb_data", i), 32'(wb_data), 32'(tbl[i].edata));
            chk($sformatf("v%0d.wr_count", i), 32'(wr_count), 32'(tbl[i].cnt));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef WBARB_FWD_EN
        // The last table row left rd7=7777 pending in the output register.
        fwd_rs = 3'd7; fwd_rt = 3'd5;
        #1;
        chk("fwd.rs_hit", 32'(fwd_rs_hit), 1);
        chk("fwd.rt_hit", 32'(fwd_rt_hit), 0);
        chk("fwd.data", 32'(fwd_data), 32'h7777);
        fwd_rs = 3'd0;
        #1;
        chk("fwd.r0_no_hit", 32'(fwd_rs_hit), 0);
`endif

        // Counter saturation starting from a fresh reset
        @(posedge clk); #1;
        reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 6, 16'(i), 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("sat%0d.wr_count", i), 32'(wr_count),
                (i < 15) ? 32'(i + 1) : 32'(CNT_MAX));
        end
        chk("sat.wb_en", 32'(wb_en), 1);

        // A reset in the middle of a granted transfer
        drive(0, 0, 0, 1, 3, 16'h0333, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_mid.pre_wb_en", 32'(wb_en), 1);
        drive(0, 0, 0, 1, 1, 16'hAAAA, 1, 2, 16'hBBBB);
        #1;
        chk("rst_mid.tie_mem", 32'(mem_ready), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid.wb_en_now", 32'(wb_en), 0);
        chk("rst_mid.wr_count_now", 32'(wr_count), 0);
        chk("rst_mid.wb_rd_now", 32'(wb_rd), 0);
        chk("rst_mid.rr_back_to_alu", 32'(alu_ready), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.no_write", 32'(wb_en), 0);
        chk("rst_mid.count", 32'(wr_count), 0);
        drive(0, 0, 0, 1, 1, 16'hAAAA, 1, 2, 16'hBBBB);
        #1;
        chk("rst_mid.first_tie_alu", 32'(alu_ready), 1);
        chk("rst_mid.first_tie_mem", 32'(mem_ready), 0);
        @(posedge clk); #1;
        chk("rst_mid.first_tie_rd", 32'(wb_rd), 1);
        drive(0, 0, 0, 0, 0, 0, 1, 2, 16'hBBBB);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized run compared against a request-level model
        reset = 1'b1; #1; reset = 1'b0;
        last_mem = 1'b1; m_en = 1'b0; m_rd = '0; m_data = '0; m_cnt = '0;
        for (int k = 0; k < 3; k++) begin p_v[k] = 1'b0; p_rd[k] = '0; p_d[k] = '0; end
        for (int c = 0; c < 600; c++) begin
            int g;
            for (int k = 0; k < 3; k++) begin
                if (!p_v[k] && $urandom_range(0, 99) < ((k == 0) ? 15 : 60)) begin
                    p_v[k]  = 1'b1;
                    p_rd[k] = ADDR_W'($urandom_range(0, 7));
                    p_d[k]  = DATA_W'($urandom);
                end
            end
            drive(p_v[0], p_rd[0], p_d[0], p_v[1], p_rd[1], p_d[1], p_v[2], p_rd[2], p_d[2]);
            #1;
            g = -1;
            if (p_v[0])                g = 0;
            else if (p_v[1] && p_v[2]) g = last_mem ? 1 : 2;
            else if (p_v[1])           g = 1;
            else if (p_v[2])           g = 2;
            chk($sformatf("rnd%0d.dbg_ready", c), 32'(dbg_ready), 32'(g == 0));
            chk($sformatf("rnd%0d.alu_ready", c), 32'(alu_ready), 32'(g == 1));
            chk($sformatf("rnd%0d.mem_ready", c), 32'(mem_ready), 32'(g == 2));
            chk($sformatf("rnd%0d.stall", c), 32'(stall),
                32'((p_v[0] && g != 0) || (p_v[1] && g != 1) || (p_v[2] && g != 2)));
            if (g >= 0) begin
                m_en   = (p_rd[g] != 0);
                m_rd   = p_rd[g];
                m_data = p_d[g];
                if (p_rd[g] != 0 && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
                if (g == 1) last_mem = 1'b0;
                if (g == 2) last_mem = 1'b1;
                p_v[g] = 1'b0;
            end else begin
                m_en = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.wb_en", c), 32'(wb_en), 32'(m_en));
            chk($sformatf("rnd%0d.wb_rd", c), 32'(wb_rd), 32'(m_rd));
            chk($sformatf("rnd%0d.wb_data", c), 32'(wb_data), 32'(m_data));
            chk($sformatf("rnd%0d.wr_count", c), 32'(wr_count), 32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
